// File: rtl/load_store_unit_pkg.sv
// Shared encodings, bus payload type and decode helpers for the load/store unit.
package load_store_unit_pkg;

  localparam int unsigned LSU_XLEN = 32;
  localparam int unsigned LSU_BE_W = 4;

  // funct3 size/sign encodings
  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  // FSM state encodings
  localparam logic [1:0] LSU_IDLE = 2'd0;
  localparam logic [1:0] LSU_REQ  = 2'd1;
  localparam logic [1:0] LSU_DONE = 2'd2;

  typedef struct packed {
    logic                we;
    logic [LSU_XLEN-1:0] addr;
    logic [LSU_BE_W-1:0] byte_en;
    logic [LSU_XLEN-1:0] wdata;
  } dmem_req_t;

  // Unknown sizes are illegal; unsigned sizes only make sense for loads.
  function automatic logic lsu_illegal(input logic [2:0] funct3, input logic is_store);
    logic res;
    case (funct3)
      LSU_B, LSU_H, LSU_W: res = 1'b0;
      LSU_BU, LSU_HU:      res = is_store;
      default:             res = 1'b1;
    endcase
    return res;
  endfunction

  function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    logic res;
    case (funct3)
      LSU_H, LSU_HU: res = offset[0];
      LSU_W:         res = (offset != 2'b00);
      default:       res = 1'b0;
    endcase
    return res;
  endfunction

  // Word-aligned request with lane enables and lane-replicated store data.
  function automatic dmem_req_t lsu_build_req(input logic is_store, input logic [2:0] funct3,
                                              input logic [LSU_XLEN-1:0] addr,
                                              input logic [LSU_XLEN-1:0] sdata);
    dmem_req_t r;
    r.we      = is_store;
    r.addr    = {addr[LSU_XLEN-1:2], 2'b00};
    r.byte_en = 4'b1111;
    r.wdata   = '0;
    if (is_store) begin
      case (funct3)
        LSU_B: begin
          r.byte_en = 4'b0001 << addr[1:0];
          r.wdata   = {4{sdata[7:0]}};
        end
        LSU_H: begin
          r.byte_en = addr[1] ? 4'b1100 : 4'b0011;
          r.wdata   = {2{sdata[15:0]}};
        end
        default: r.wdata = sdata;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module load_extend
  import load_store_unit_pkg::*;
(
  input  logic [LSU_XLEN-1:0] rdata,
  input  logic [1:0]          offset,
  input  logic [2:0]          funct3,
  output logic [LSU_XLEN-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (funct3)
      LSU_B:   result = {{24{byte_sel[7]}}, byte_sel};
      LSU_BU:  result = {24'h0, byte_sel};
      LSU_H:   result = {{16{half_sel[15]}}, half_sel};
      LSU_HU:  result = {16'h0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: stalls the pipeline around a variable-latency
// request/ack data-memory access and returns extended load data or a fault.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic            i_memRead,
  input  logic            i_memWrite,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_storeData,
  output logic            o_stall,
  output logic            o_done,
  output logic [XLEN-1:0] o_loadData,
  output logic            o_misaligned,
  output logic            o_busErr,
  output logic            o_dmemReq,
  output logic            o_dmemWe,
  output logic [XLEN-1:0] o_dmemAddr,
  output logic [3:0]      o_dmemByteEn,
  output logic [XLEN-1:0] o_dmemWData,
  input  logic            i_dmemAck,
  input  logic [XLEN-1:0] i_dmemRData
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  logic [1:0]      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]      off_q, off_n;
  logic [2:0]      f3_q, f3_n;
  dmem_req_t       req_q, req_n;
  logic [XLEN-1:0] load_q, load_n;
  logic            mis_q, mis_n;
  logic            berr_q, berr_n;
  logic [XLEN-1:0] ext_data;
  logic            access;
  logic            in_req;

  assign access = i_valid & (i_memRead | i_memWrite);
  assign in_req = (state == LSU_REQ);

  load_extend u_load_extend (
    .rdata  (i_dmemRData),
    .offset (off_q),
    .funct3 (f3_q),
    .result (ext_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= LSU_IDLE;
    else       state <= state_n;
  end

  // Next-state and next-register values; result flags only live for the DONE cycle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    off_n   = off_q;
    f3_n    = f3_q;
    req_n   = req_q;
    load_n  = '0;
    mis_n   = 1'b0;
    berr_n  = 1'b0;
    case (state)
      LSU_IDLE: begin
        if (access) begin
          off_n = i_addr[1:0];
          f3_n  = i_funct3;
          req_n = lsu_build_req(i_memWrite, i_funct3, i_addr, i_storeData);
          cnt_n = '0;
          if (lsu_illegal(i_funct3, i_memWrite)) begin
            berr_n  = 1'b1;
            state_n = LSU_DONE;
          end else if (lsu_misaligned(i_funct3, i_addr[1:0])) begin
            mis_n   = 1'b1;
            state_n = LSU_DONE;
          end else begin
            state_n = LSU_REQ;
          end
        end
      end
      LSU_REQ: begin
        cnt_n = cnt + CNT_W'(1);
        if (i_dmemAck) begin
          load_n  = req_q.we ? '0 : ext_data;
          state_n = LSU_DONE;
        end else if (cnt == CNT_W'(MAX_WAIT - 1)) begin
          berr_n  = 1'b1;
          state_n = LSU_DONE;
        end
      end
      LSU_DONE: state_n = LSU_IDLE;
      default:  state_n = LSU_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt    <= '0;
      off_q  <= '0;
      f3_q   <= '0;
      req_q  <= '0;
      load_q <= '0;
      mis_q  <= 1'b0;
      berr_q <= 1'b0;
    end else begin
      cnt    <= cnt_n;
      off_q  <= off_n;
      f3_q   <= f3_n;
      req_q  <= req_n;
      load_q <= load_n;
      mis_q  <= mis_n;
      berr_q <= berr_n;
    end
  end

  assign o_stall      = ((state == LSU_IDLE) & access) | in_req;
  assign o_done       = (state == LSU_DONE);
  assign o_loadData   = load_q;
  assign o_misaligned = mis_q;
  assign o_busErr     = berr_q;

  // Bus is driven only while a request is outstanding.
  assign o_dmemReq    = in_req;
  assign o_dmemWe     = in_req & req_q.we;
  assign o_dmemAddr   = in_req ? req_q.addr    : '0;
  assign o_dmemByteEn = in_req ? req_q.byte_en : 4'b0000;
  assign o_dmemWData  = in_req ? req_q.wdata   : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed accesses with a scripted memory responder.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int unsigned MAXW   = 4;
  localparam int          BUDGET = 40;

  logic        clk;
  logic        i_rst, i_valid, i_memRead, i_memWrite;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr, i_storeData;
  logic        o_stall, o_done, o_misaligned, o_busErr;
  logic [31:0] o_loadData;
  logic        o_dmemReq, o_dmemWe;
  logic [31:0] o_dmemAddr, o_dmemWData;
  logic [3:0]  o_dmemByteEn;
  logic        i_dmemAck;
  logic [31:0] i_dmemRData;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        mis;
    logic        berr;
  } resp_t;
  resp_t sb_q[$];

  load_store_unit #(.XLEN(32), .MAX_WAIT(MAXW)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_memRead(i_memRead),
    .i_memWrite(i_memWrite), .i_funct3(i_funct3), .i_addr(i_addr),
    .i_storeData(i_storeData), .o_stall(o_stall), .o_done(o_done),
    .o_loadData(o_loadData), .o_misaligned(o_misaligned), .o_busErr(o_busErr),
    .o_dmemReq(o_dmemReq), .o_dmemWe(o_dmemWe), .o_dmemAddr(o_dmemAddr),
    .o_dmemByteEn(o_dmemByteEn), .o_dmemWData(o_dmemWData),
    .i_dmemAck(i_dmemAck), .i_dmemRData(i_dmemRData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected response whenever the DUT reports completion.
  always @(negedge clk) begin : monitor
    resp_t e;
    if (!i_rst) begin
      if (o_done) begin
        if (sb_q.size() == 0) begin
          check32("unexpected_done", 32'h1, 32'h0);
        end else begin
          e = sb_q.pop_front();
          check32("load_data", o_loadData, e.data);
          check32("misaligned", {31'b0, o_misaligned}, {31'b0, e.mis});
          check32("bus_err", {31'b0, o_busErr}, {31'b0, e.berr});
        end
      end else begin
        check32("quiet_when_not_done", o_loadData | {30'b0, o_misaligned, o_busErr}, 32'h0);
      end
    end
  end

  task automatic clear_inputs();
    i_valid = 0; i_memRead = 0; i_memWrite = 0; i_funct3 = 3'b000;
    i_addr = '0; i_storeData = '0; i_dmemAck = 0; i_dmemRData = '0;
  endtask

  // Issues one access and plays memory: ack on REQ cycle number ack_after+1 (-1 = never).
  task automatic access(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sd,
                        input int ack_after, input logic [31:0] rdata,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd, input logic exp_we, input int exp_cyc,
                        input logic [31:0] exp_ld, input logic exp_mis, input logic exp_berr);
    int  cyc;
    int  reqs;
    int  exp_reqs;
    bit  done_seen;
    @(negedge clk);
    check32({tag, "_no_reissue"}, {31'b0, o_dmemReq}, 32'h0);
    i_valid = 1; i_memRead = rd; i_memWrite = wr; i_funct3 = f3;
    i_addr = addr; i_storeData = sd; i_dmemAck = 0;
    sb_q.push_back(resp_t'{data: exp_ld, mis: exp_mis, berr: exp_berr});
    #1 check32({tag, "_stall_idle"}, {31'b0, o_stall}, 32'h1);
    cyc = 1; reqs = 0; done_seen = 0;
    while (!done_seen && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      i_dmemAck = 0; i_dmemRData = '0;
      if (o_done) begin
        done_seen = 1;
        check32({tag, "_done_cycle"}, cyc, exp_cyc);
        #1 check32({tag, "_stall_done"}, {31'b0, o_stall}, 32'h0);
      end else if (o_dmemReq) begin
        reqs++;
        check32({tag, "_stall_req"}, {31'b0, o_stall}, 32'h1);
        if (reqs == 1) begin
          check32({tag, "_addr"}, o_dmemAddr, exp_addr);
          check32({tag, "_byte_en"}, {28'b0, o_dmemByteEn}, {28'b0, exp_be});
          check32({tag, "_we"}, {31'b0, o_dmemWe}, {31'b0, exp_we});
          if (exp_we) check32({tag, "_wdata"}, o_dmemWData, exp_wd);
        end
        if (reqs == ack_after + 1) begin
          i_dmemAck = 1; i_dmemRData = rdata;
        end
      end
    end
    if (!done_seen) check32({tag, "_timeout_waiting_done"}, 32'h0, 32'h1);
    exp_reqs = (exp_cyc > 2) ? exp_cyc - 2 : 0;
    check32({tag, "_req_cycles"}, reqs, exp_reqs);
  endtask

  initial begin
    clear_inputs();
    i_rst = 1;
    repeat (3) @(negedge clk);
    check32("rst_outputs", {o_stall, o_done, o_misaligned, o_busErr, o_dmemReq, o_dmemWe, o_dmemByteEn}, 32'h0);
    check32("rst_load_data", o_loadData, 32'h0);
    check32("rst_dmem_addr", o_dmemAddr | o_dmemWData, 32'h0);
    i_rst = 0;

    //      tag     rd wr f3      addr          sdata         ack rdata         exp_addr      be       wdata         we cyc ld            mis berr
    access("sw",    0, 1, LSU_W,  32'h100,      32'hDEADBEEF, 0,  32'h0,        32'h100,      4'b1111, 32'hDEADBEEF, 1, 3,  32'h0,        0, 0);
    access("lb",    1, 0, LSU_B,  32'h103,      32'h0,        2,  32'h80FF0000, 32'h100,      4'b1111, 32'h0,        0, 5,  32'hFFFFFF80, 0, 0);
    access("lhu",   1, 0, LSU_HU, 32'h102,      32'h0,        0,  32'h80FF0000, 32'h100,      4'b1111, 32'h0,        0, 3,  32'h000080FF, 0, 0);
    access("sb",    0, 1, LSU_B,  32'h101,      32'h000000A5, 0,  32'h0,        32'h100,      4'b0010, 32'hA5A5A5A5, 1, 3,  32'h0,        0, 0);
    access("sh",    0, 1, LSU_H,  32'h106,      32'h1234ABCD, 0,  32'h0,        32'h104,      4'b1100, 32'hABCDABCD, 1, 3,  32'h0,        0, 0);
    access("lh",    1, 0, LSU_H,  32'h100,      32'h0,        1,  32'h1234F00D, 32'h100,      4'b1111, 32'h0,        0, 4,  32'hFFFFF00D, 0, 0);
    access("lbu",   1, 0, LSU_BU, 32'h102,      32'h0,        0,  32'h00C30000, 32'h100,      4'b1111, 32'h0,        0, 3,  32'h000000C3, 0, 0);
    access("lw_mis",1, 0, LSU_W,  32'h102,      32'h0,        0,  32'h0,        32'h100,      4'b1111, 32'h0,        0, 2,  32'h0,        1, 0);
    access("lh_mis",1, 0, LSU_H,  32'h101,      32'h0,        0,  32'h0,        32'h100,      4'b1111, 32'h0,        0, 2,  32'h0,        1, 0);
    access("f3_011",1, 0, 3'b011, 32'h100,      32'h0,        0,  32'h0,        32'h100,      4'b1111, 32'h0,        0, 2,  32'h0,        0, 1);
    access("sbu",   0, 1, LSU_BU, 32'h100,      32'h0,        0,  32'h0,        32'h100,      4'b1111, 32'h0,        1, 2,  32'h0,        0, 1);
    access("rdwr",  1, 1, LSU_W,  32'h204,      32'h0BADF00D, 0,  32'hFFFFFFFF, 32'h204,      4'b1111, 32'h0BADF00D, 1, 3,  32'h0,        0, 0);
    access("tmo",   1, 0, LSU_W,  32'h200,      32'h0,        -1, 32'h0,        32'h200,      4'b1111, 32'h0,        0, 6,  32'h0,        0, 1);
    access("ack_last",1,0, LSU_W, 32'h010,      32'h0,        3,  32'h12345678, 32'h010,      4'b1111, 32'h0,        0, 6,  32'h12345678, 0, 0);

    // Non-memory instruction: no stall, no request.
    @(negedge clk);
    clear_inputs();
    i_valid = 1;
    #1 check32("nonmem_stall", {31'b0, o_stall}, 32'h0);
    @(negedge clk);
    check32("nonmem_no_req", {30'b0, o_dmemReq, o_done}, 32'h0);

    // Reset while in REQ: request drops next cycle, no completion, late ack ignored.
    clear_inputs();
    i_valid = 1; i_memRead = 1; i_funct3 = LSU_W; i_addr = 32'h300;
    @(negedge clk);
    check32("rst_req_entered", {31'b0, o_dmemReq}, 32'h1);
    @(negedge clk);
    check32("rst_req_held", {31'b0, o_dmemReq}, 32'h1);
    clear_inputs();
    i_rst = 1;
    @(negedge clk);
    check32("rst_req_dropped", {30'b0, o_dmemReq, o_done}, 32'h0);
    i_rst = 0;
    i_dmemAck = 1; i_dmemRData = 32'hCAFEF00D;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check32("late_ack_ignored", {29'b0, o_dmemReq, o_done, o_stall}, 32'h0);
    end
    clear_inputs();

    repeat (2) @(negedge clk);
    check32("scoreboard_drained", sb_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
